// File: rtl/alu_issue_ctrl.sv
// RV32I ALU issue stage: decodes R/I/branch words into a held micro-op
// and stalls new issue until the ALU resolves an issued branch.
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  alu_op,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic        use_imm,
    output logic        is_branch,
    input  logic        alu_zero,
    input  logic        alu_done,
    output logic        br_taken,
    output logic        illegal
);

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;
    localparam logic [6:0] OPC_B = 7'b1100011;

    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b00101;
    localparam logic [4:0] OP_XOR  = 5'b00110;
    localparam logic [4:0] OP_SLT  = 5'b01000;
    localparam logic [4:0] OP_SLTU = 5'b01001;
    localparam logic [4:0] OP_SLL  = 5'b01010;
    localparam logic [4:0] OP_SRL  = 5'b01011;
    localparam logic [4:0] OP_SRA  = 5'b01100;
    localparam logic [4:0] OP_BEQ  = 5'b01101;
    localparam logic [4:0] OP_BNE  = 5'b01110;

    typedef enum logic {RUN, WAIT_BR} state_t;

    state_t      state;
    logic        started;
    logic        in_fire;
    logic        out_fire;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        alt;
    logic        f7z;
    logic [4:0]  aop;
    logic        d_ok;
    logic [4:0]  d_op;
    logic [4:0]  d_rs2;
    logic [4:0]  d_rd;
    logic [31:0] d_imm;
    logic        d_use;
    logic        d_br;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];
    assign alt = (f7 == 7'b0100000);
    assign f7z = (f7 == 7'b0000000);

    // WAIT_BR reopens issue in the very cycle the ALU reports back
    assign in_ready = started
                   && (state == RUN || (state == WAIT_BR && alu_done))
                   && (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign br_taken = (state == WAIT_BR) && alu_done && alu_zero;

    always_comb begin
        unique case (f3)
            3'b000:  aop = alt ? OP_SUB : OP_ADD;
            3'b001:  aop = OP_SLL;
            3'b010:  aop = OP_SLT;
            3'b011:  aop = OP_SLTU;
            3'b100:  aop = OP_XOR;
            3'b101:  aop = alt ? OP_SRA : OP_SRL;
            3'b110:  aop = OP_OR;
            default: aop = OP_AND;
        endcase
    end

    always_comb begin
        d_ok  = 1'b0;
        d_op  = 5'd0;
        d_rs2 = instr[24:20];
        d_rd  = instr[11:7];
        d_imm = 32'd0;
        d_use = 1'b0;
        d_br  = 1'b0;
        case (opc)
            OPC_R: begin
                d_ok = f7z || (alt && (f3 == 3'b000 || f3 == 3'b101));
                d_op = aop;
            end
            OPC_I: begin
                d_use = 1'b1;
                d_rs2 = 5'd0;
                d_op  = (f3 == 3'b000) ? OP_ADD : aop;
                d_imm = {{20{instr[31]}}, instr[31:20]};
                d_ok  = 1'b1;
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    d_imm = {27'd0, instr[24:20]};
                    d_ok  = f7z || (alt && f3 == 3'b101);
                end
            end
            OPC_B: begin
                d_br  = 1'b1;
                d_rd  = 5'd0;
                d_ok  = (f3 == 3'b000 || f3 == 3'b001);
                d_op  = f3[0] ? OP_BNE : OP_BEQ;
                d_imm = {{20{instr[31]}}, instr[7], instr[30:25],
                         instr[11:8], 1'b0};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            started   <= 1'b0;
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            alu_op    <= 5'd0;
            rs1       <= 5'd0;
            rs2       <= 5'd0;
            rd        <= 5'd0;
            imm       <= 32'd0;
            use_imm   <= 1'b0;
            is_branch <= 1'b0;
        end else begin
            started <= 1'b1;
            illegal <= in_fire && !d_ok;
            if (in_fire) begin
                out_valid <= d_ok;
                if (d_ok) begin
                    alu_op    <= d_op;
                    rs1       <= instr[19:15];
                    rs2       <= d_rs2;
                    rd        <= d_rd;
                    imm       <= d_imm;
                    use_imm   <= d_use;
                    is_branch <= d_br;
                end
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
            // a branch leaving while the previous one resolves keeps us waiting
            unique case (state)
                RUN: begin
                    if (out_fire && is_branch)
                        state <= WAIT_BR;
                end
                WAIT_BR: begin
                    if (alu_done && !(out_fire && is_branch))
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: tasks push expected micro-ops,
// a negedge monitor pops and compares them on each output transfer.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        is_branch;
    logic        alu_zero = 1'b0;
    logic        alu_done = 1'b0;
    logic        br_taken;
    logic        illegal;

    typedef struct packed {
        logic [4:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        ui;
        logic        br;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_op    (alu_op),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .imm       (imm),
        .use_imm   (use_imm),
        .is_branch (is_branch),
        .alu_zero  (alu_zero),
        .alu_done  (alu_done),
        .br_taken  (br_taken),
        .illegal   (illegal)
    );

    function automatic exp_t mk(input logic [4:0] op, input logic [4:0] a,
                                input logic [4:0] b, input logic [4:0] d,
                                input logic [31:0] im, input logic ui,
                                input logic br);
        exp_t e;
        e.op = op; e.rs1 = a; e.rs2 = b; e.rd = d;
        e.imm = im; e.ui = ui; e.br = br;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected got op=%b rd=%0d exp=none",
                         alu_op, rd);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (alu_op !== e.op || rs1 !== e.rs1 || rd !== e.rd
                    || (!e.ui && rs2 !== e.rs2)
                    || ((e.ui || e.br) && imm !== e.imm)
                    || use_imm !== e.ui || is_branch !== e.br)
                    $display("FAIL sb_uop got op=%b rs1=%0d rs2=%0d rd=%0d imm=%h ui=%b br=%b exp op=%b rs1=%0d rs2=%0d rd=%0d imm=%h ui=%b br=%b",
                             alu_op, rs1, rs2, rd, imm, use_imm, is_branch,
                             e.op, e.rs1, e.rs2, e.rd, e.imm, e.ui, e.br);
                else
                    passed++;
            end
        end
    end

    task automatic send(input logic [31:0] w, input exp_t e,
                        input bit legal);
        int n;
        n = 0;
        instr = w;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            $display("FAIL send_timeout got in_ready=0 exp=1 instr=%h", w);
        end else if (legal) begin
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({in_ready, out_valid, br_taken, illegal, alu_op, rs1, rs2, rd,
             imm, use_imm, is_branch} !== '0)
            $display("FAIL reset_outputs got rdy=%b ov=%b op=%b imm=%h exp=all 0",
                     in_ready, out_valid, alu_op, imm);
        else
            passed++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0)
            $display("FAIL reset_release_rdy got=%b exp=0", in_ready);
        else
            passed++;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1)
            $display("FAIL first_edge_rdy got=%b exp=1", in_ready);
        else
            passed++;
    endtask

    task automatic test_rtype();
        out_ready = 1'b1;
        send(32'h002081B3, mk(5'b00001, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b0), 1);
        checks++;
        if (out_valid !== 1'b1 || alu_op !== 5'b00001)
            $display("FAIL add_latency got ov=%b op=%b exp ov=1 op=00001",
                     out_valid, alu_op);
        else
            passed++;
        send(32'h407302B3, mk(5'b00011, 5'd6, 5'd7, 5'd5, 32'd0, 1'b0, 1'b0), 1);
        send(32'h403150B3, mk(5'b01100, 5'd2, 5'd3, 5'd1, 32'd0, 1'b0, 1'b0), 1);
        send(32'h0062B233, mk(5'b01001, 5'd5, 5'd6, 5'd4, 32'd0, 1'b0, 1'b0), 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_itype();
        send(32'hFFF00093, mk(5'b00001, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 1'b1, 1'b0), 1);
        send(32'h4030D093, mk(5'b01100, 5'd1, 5'd0, 5'd1, 32'd3, 1'b1, 1'b0), 1);
        send(32'h0F01F113, mk(5'b00100, 5'd3, 5'd0, 5'd2, 32'h000000F0, 1'b1, 1'b0), 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_branch();
        send(32'h00208463, mk(5'b01101, 5'd1, 5'd2, 5'd0, 32'd8, 1'b0, 1'b1), 1);
        @(posedge clk);
        #1;
        instr = 32'h002081B3;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || br_taken !== 1'b0)
                $display("FAIL wait_br_stall got rdy=%b bt=%b exp rdy=0 bt=0",
                         in_ready, br_taken);
            else
                passed++;
            @(posedge clk);
            #1;
        end
        alu_done = 1'b1;
        alu_zero = 1'b1;
        #1;
        checks++;
        if (br_taken !== 1'b1 || in_ready !== 1'b1)
            $display("FAIL br_resolve got bt=%b rdy=%b exp bt=1 rdy=1",
                     br_taken, in_ready);
        else
            passed++;
        sb.push_back(mk(5'b00001, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_done = 1'b0;
        alu_zero = 1'b0;
        #1;
        checks++;
        if (br_taken !== 1'b0 || out_valid !== 1'b1)
            $display("FAIL br_pulse_end got bt=%b ov=%b exp bt=0 ov=1",
                     br_taken, out_valid);
        else
            passed++;
        @(posedge clk);
        #1;
        alu_done = 1'b1;
        alu_zero = 1'b1;
        #1;
        checks++;
        if (br_taken !== 1'b0)
            $display("FAIL run_ignores_done got bt=%b exp=0", br_taken);
        else
            passed++;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1)
            $display("FAIL run_after_done got rdy=%b exp=1", in_ready);
        else
            passed++;
        alu_done = 1'b0;
        alu_zero = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send(32'h002081B3, mk(5'b00001, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b0), 1);
        instr = 32'h407302B3;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1
                || alu_op !== 5'b00001 || rd !== 5'd3)
                $display("FAIL stall_hold got rdy=%b ov=%b op=%b rd=%0d exp rdy=0 ov=1 op=00001 rd=3",
                         in_ready, out_valid, alu_op, rd);
            else
                passed++;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL stall_release got rdy=%b exp=1", in_ready);
        end else begin
            passed++;
            sb.push_back(mk(5'b00011, 5'd6, 5'd7, 5'd5, 32'd0, 1'b0, 1'b0));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || alu_op !== 5'b00011)
            $display("FAIL b2b_reload got ov=%b op=%b exp ov=1 op=00011",
                     out_valid, alu_op);
        else
            passed++;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_illegal();
        exp_t none;
        none = '0;
        send(32'h0000007F, none, 0);
        checks++;
        if (illegal !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL illegal_pulse got ill=%b ov=%b exp ill=1 ov=0",
                     illegal, out_valid);
        else
            passed++;
        @(posedge clk);
        #1;
        checks++;
        if (illegal !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL illegal_once got ill=%b ov=%b exp ill=0 ov=0",
                     illegal, out_valid);
        else
            passed++;
        send(32'h022081B3, none, 0);
        checks++;
        if (illegal !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL illegal_funct7 got ill=%b ov=%b exp ill=1 ov=0",
                     illegal, out_valid);
        else
            passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_wait_br();
        send(32'h00208463, mk(5'b01101, 5'd1, 5'd2, 5'd0, 32'd8, 1'b0, 1'b1), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        alu_done = 1'b1;
        alu_zero = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, br_taken, illegal, alu_op, rs1, rs2, rd,
             imm, use_imm, is_branch} !== '0)
            $display("FAIL reset_in_wait got rdy=%b ov=%b bt=%b op=%b imm=%h exp=all 0",
                     in_ready, out_valid, br_taken, alu_op, imm);
        else
            passed++;
        @(posedge clk);
        #1;
        alu_done = 1'b0;
        alu_zero = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || br_taken !== 1'b0 || illegal !== 1'b0)
            $display("FAIL reset_recover got rdy=%b bt=%b ill=%b exp rdy=1 bt=0 ill=0",
                     in_ready, br_taken, illegal);
        else
            passed++;
        send(32'h002081B3, mk(5'b00001, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b0), 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_branch();
        test_back_to_back();
        test_illegal();
        test_reset_wait_br();
        checks++;
        if (sb.size() != 0)
            $display("FAIL sb_drain got=%0d exp=0", sb.size());
        else
            passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
